// File: rtl/uart_rx_os.sv
// ============================================================================
// Module   : uart_rx_os
// Brief    : Oversampling 8N1 UART receiver (optional parity), valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os #(
    parameter int CLKS_PER_BIT = 104,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam int            H      = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] C_H    = CW'(H);
    localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    smp_q, smp_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_pend_q, par_pend_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          overrun_q, overrun_d;
    logic          maj, decide, commit, commit_fe;

    // Synchronizer idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            smp_q        <= 2'b11;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_pend_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            smp_q        <= smp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_pend_q   <= par_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        smp_d        = smp_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        commit       = 1'b0;
        commit_fe    = 1'b0;

        // Third sample is taken live at the decision point.
        maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
        decide = (cnt_q == C_HP1);

        if (state_q != S_IDLE && state_q != S_BREAK) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
            if (cnt_q == C_HM1) smp_d[0] = rx_s_q;
            if (cnt_q == C_H)   smp_d[1] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_idx_d  = 3'd0;
                    par_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (decide) state_d = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_pend_d = ((^shift_q) ^ PARITY_ODD) != maj;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    commit    = 1'b1;
                    commit_fe = ~maj;
                    state_d   = maj ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                frame_err_d  = commit_fe;
                parity_err_d = par_pend_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module   : tb_uart_rx_os
// Brief    : Scoreboard bench for uart_rx_os (8N1 and odd-parity instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_os;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx0, rx1;
    logic       rx_ready0, rx_ready1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       overrun0, overrun1;
    logic       busy0, busy1;

    int checks   = 0;
    int failures = 0;
    int ovr0     = 0;
    int ovr1     = 0;

    // Expected entries: {data, frame_err, parity_err}
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .frame_err(frame_err0), .parity_err(parity_err0),
        .overrun(overrun0), .busy(busy0)
    );

    uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .frame_err(frame_err1), .parity_err(parity_err1),
        .overrun(overrun1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && rx_valid0 && rx_ready0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_byte got=%0h fe=%0b pe=%0b expected=none",
                         rx_data0, frame_err0, parity_err0);
            end else begin
                logic [9:0] e0;
                e0 = q0.pop_front();
                if ({rx_data0, frame_err0, parity_err0} !== e0) begin
                    failures++;
                    $display("FAIL dut0_byte got=%0h/%0b/%0b expected=%0h/%0b/%0b",
                             rx_data0, frame_err0, parity_err0, e0[9:2], e0[1], e0[0]);
                end
            end
        end
        if (rst_n && rx_valid1 && rx_ready1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_byte got=%0h fe=%0b pe=%0b expected=none",
                         rx_data1, frame_err1, parity_err1);
            end else begin
                logic [9:0] e1;
                e1 = q1.pop_front();
                if ({rx_data1, frame_err1, parity_err1} !== e1) begin
                    failures++;
                    $display("FAIL dut1_byte got=%0h/%0b/%0b expected=%0h/%0b/%0b",
                             rx_data1, frame_err1, parity_err1, e1[9:2], e1[1], e1[0]);
                end
            end
        end
        if (overrun0) ovr0++;
        if (overrun1) ovr1++;
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (has_par) drive(sel, par);
        drive(sel, stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ovr_base;
        rst_n     = 1'b0;
        rx0       = 1'b1;
        rx1       = 1'b1;
        rx_ready0 = 1'b1;
        rx_ready1 = 1'b1;
        idle(3);
        check("rst_rx_valid", rx_valid0, 0);
        check("rst_rx_data", rx_data0, 0);
        check("rst_flags", {frame_err0, parity_err0, overrun0}, 0);
        check("rst_busy", busy0, 0);
        rst_n = 1'b1;
        idle(2 * CPB);

        // Single byte 0xA5
        q0.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        check("a5_delivered", q0.size(), 0);
        check("a5_busy_low", busy0, 0);

        // Glitch of 4 clocks must be rejected
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(20);
        check("glitch_busy_low", busy0, 0);
        check("glitch_no_valid", rx_valid0, 0);

        // Back-to-back frames with no idle gap
        q0.push_back({8'h00, 1'b0, 1'b0});
        q0.push_back({8'hFF, 1'b0, 1'b0});
        q0.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        check("b2b_delivered", q0.size(), 0);
        check("b2b_no_overrun", ovr0, 0);

        // Framing error then a long low line, then a good byte
        q0.push_back({8'h55, 1'b1, 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(40);
        check("break_busy", busy0, 1);
        rx0 = 1'b1;
        idle(2 * CPB);
        check("break_back_idle", busy0, 0);
        q0.push_back({8'h81, 1'b0, 1'b0});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        check("ferr_seq_delivered", q0.size(), 0);

        // Odd parity: 0x07 has three ones, so the correct parity bit is 0
        q1.push_back({8'h07, 1'b0, 1'b0});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(CPB);
        q1.push_back({8'h07, 1'b0, 1'b1});
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(CPB);
        check("parity_delivered", q1.size(), 0);

        // Overrun: consumer stalled across two frames
        rx_ready0 = 1'b0;
        ovr_base  = ovr0;
        q0.push_back({8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        check("ovr_valid_held", rx_valid0, 1);
        check("ovr_data_held", rx_data0, 8'h11);
        check("ovr_pulse_count", ovr0 - ovr_base, 1);
        rx_ready0 = 1'b1;
        idle(3);
        check("ovr_accepted_valid_low", rx_valid0, 0);
        check("ovr_queue_empty", q0.size(), 0);

        // Reset in the middle of a frame
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b0);
        check("midframe_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_valid", rx_valid0, 0);
        check("midrst_data", rx_data0, 0);
        check("midrst_flags", {frame_err0, parity_err0, overrun0}, 0);
        rx0 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(12 * CPB);
        check("midrst_no_byte_valid", rx_valid0, 0);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        check("final_overruns", ovr0 + ovr1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bounded run time regardless of stimulus
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
